// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake and a WIDTH-cycle shift-add multiplier.
// Define ALU_SEQ_DIV_EN to add the WIDTH-cycle restoring divider for op 10 (DIVU).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags
);
  // state  | meaning
  // S_IDLE | ready; single-cycle ops complete from here
  // S_MUL  | shift-add multiply, one partial product per cycle
  // S_DIV  | restoring divide, one quotient bit per cycle

  localparam int LG = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_SEQ_DIV_EN
    , S_DIV
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [LG-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
`ifdef ALU_SEQ_DIV_EN
  logic             dz_q, dz_d;
`endif

  logic [LG-1:0]    sh;
  logic [WIDTH:0]   add_sum, sub_dif, shl_w, shr_w, sar_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ok;

  // Shifts carry one extra bit so the last bit shifted out falls out as C.
  assign sh      = b[LG-1:0];
  assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_dif = {1'b0, a} - {1'b0, b};
  assign shl_w   = {1'b0, a} << sh;
  assign shr_w   = {a, 1'b0} >> sh;
  assign sar_w   = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_dif[WIDTH-1:0];
        alu_c   = sub_dif[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SAR: begin
        alu_res = sar_w[WIDTH:1];
        alu_c   = sar_w[0];
      end
      default: alu_ok = 1'b0;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_sum = acc_lo_q[0] ? (acc_hi_q + {1'b0, opnd_q}) : acc_hi_q;
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_sh, div_sub, div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             div_ge;

  assign div_sh  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, opnd_q};
  assign div_ge  = (div_sh >= {1'b0, opnd_q});
  assign div_rem = div_ge ? div_sub : div_sh;
  assign div_quo = {acc_lo_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    dz_d     = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = a;
            opnd_d   = b;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (op == OP_DIVU) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = a;
            opnd_d   = b;
            dz_d     = (b == '0);
          end
`endif
          else begin
            done_d   = 1'b1;
            res_lo_d = alu_res;
            res_hi_d = '0;
            flags_d  = alu_ok ? {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v} : 4'b0000;
          end
        end
      end
      S_MUL: begin
        cnt_d    = cnt_q + 1'b1;
        acc_hi_d = {1'b0, mul_hi};
        acc_lo_d = mul_lo;
        if (cnt_q == LG'(WIDTH - 1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          res_lo_d = mul_lo;
          res_hi_d = mul_hi;
          flags_d  = {mul_lo[WIDTH-1], mul_lo == '0, |mul_hi, |mul_hi};
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        cnt_d    = cnt_q + 1'b1;
        acc_hi_d = div_rem;
        acc_lo_d = div_quo;
        if (cnt_q == LG'(WIDTH - 1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          res_lo_d = div_quo;
          res_hi_d = div_rem[WIDTH-1:0];
          flags_d  = {div_quo[WIDTH-1], div_quo == '0, 1'b0, dz_q};
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_DIV_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign flags  = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU core's combinational ALU. It adds an operation select, a start/busy/done handshake, a status-flag output, and a multi-cycle unsigned shift-add multiplier; a restoring divider is optional. The CPU execute stage drives it and stalls on `busy`. It replaces the wide array multiplier with a WIDTH-cycle iterative unit.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a power of two, ≥ 8.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  4  operation code, sampled on accept.
- `a`, `b`  in  WIDTH  operands, sampled on accept.
- `cin`  in  1  carry-in; used by ADD only.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `res_lo`  out  WIDTH  result, or low product, or quotient.
- `res_hi`  out  WIDTH  high product, or remainder; 0 for other ops.
- `flags`  out  4  {N,Z,C,V}.

## Operation
Op codes:
- 0 ADD: `a+b+cin`.
- 1 SUB: `a-b`.
- 2 AND, 3 OR, 4 XOR.
- 5 NOT: `~a`.
- 6 SHL: logical left.
- 7 SHR: logical right.
- 8 SAR: arithmetic right.
- 9 MULU: unsigned multiply, 2·WIDTH-bit product.
- 10 DIVU: unsigned divide (see Configuration).
- 11–15: illegal.

Arithmetic and width rules:
- Shift amount is `b[log2(WIDTH)-1:0]`; upper bits of `b` are ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- Illegal op: result 0, flags 0, single-cycle.

Flags:
- N = `res_lo[WIDTH-1]`; Z = (`res_lo`==0).
- ADD: C = carry-out; V = signed overflow.
- SUB: C = borrow (`a`<`b` unsigned); V = signed overflow.
- Logic ops: C = V = 0.
- Shifts: C = last bit shifted out (0 when amount is 0); V = 0.
- MULU: C = V = (`res_hi`≠0).

State machine:
- States: IDLE, MUL, DIV.
- IDLE + accept + single-cycle op: compute, register results and flags, pulse `done`; stay in IDLE.
- IDLE + accept + MULU/DIVU: latch operands, iteration counter ← 0, `busy`←1, enter MUL/DIV.
- MUL/DIV: one iteration per cycle (shift-add or restore-subtract). After iteration WIDTH-1: registers results, `busy`←0, pulses `done`, returns to IDLE.

Boundary conditions:
- `start` while `busy`=1 is ignored; no queuing.
- `res_lo`, `res_hi` and `flags` hold their value until the next `done`. Intermediate iteration state is never visible on them.
- `start` in the same cycle as `done`: accepted, because `busy` is already 0.
- `rst_n`=0 in any state, including mid-iteration: abort, return to IDLE, all outputs ← 0.

## Timing
- Reset values: `busy`=0, `done`=0, `res_lo`=0, `res_hi`=0, `flags`=0.
- Single-cycle ops: start accepted at edge k → `done`=1 and results valid after edge k+1 (latency 1).
- MULU/DIVU: `busy`=1 after edges k+1..k+WIDTH. `done`=1 and results valid after edge k+WIDTH+1 (latency WIDTH+1; 33 for WIDTH=32).
- `done` is high for exactly one cycle per accepted request.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU is implemented as a WIDTH-cycle restoring divider; `res_lo` = quotient, `res_hi` = remainder, C = 0.
  - Divide by zero: quotient all-ones, remainder = `a`, V = 1; full latency still applies.
- `ALU_SEQ_DIV_EN` undefined: op 10 is treated as illegal (single-cycle, result 0, flags 0), and no DIV state or divider datapath is synthesised.

## Test plan
All scenarios use WIDTH=32.
- ADD `a`=2, `b`=6, `cin`=1 → `res_lo`=9, flags 0000, `done` one cycle after start; then `a`=`b`=FFFFFFFF, `cin`=0 → `res_lo`=FFFFFFFE, N=1, C=1.
- SUB `a`=10, `b`=-20 → `res_lo`=30, C=1, V=0; SAR `a`=80000301, `b`=2 → E00000C0, C=0; SHR same operands → 200000C0.
- MULU `a`=`b`=7FFFFFFF → `busy` high for 32 cycles, `done` 33 cycles after start, `res_hi`=3FFFFFFF, `res_lo`=00000001, C=V=1.
- MULU in flight, `start` with ADD asserted mid-operation → ignored; only a single `done` (for the MUL) is seen; a back-to-back start on the `done` cycle is accepted.
- `rst_n`=0 during MUL iteration 10 → next cycle `busy`=0, all outputs 0, no `done`; a following ADD works normally.
- With `ALU_SEQ_DIV_EN`: DIVU 100/7 → `res_lo`=14, `res_hi`=2 after 33 cycles; 5/0 → FFFFFFFF, 5, V=1. Without the macro: op 10 → `done` after 1 cycle, `res_lo`=0.
